// File: rtl/cu_step_sequencer_if.sv
// Link between the step sequencer and the parts it controls: the CPU step
// counter and the memory bus handshake. The master side is the sequencer;
// the slave side is the step counter and bus interface it drives.
interface cu_step_sequencer_if;
  logic [4:0] i_Step;
  logic       o_Step_Enable;
  logic       o_Step_Reset;
  logic       i_Mem_Cycle;
  logic       i_Mem_Ack;
  logic       o_Mem_Req;

  modport master (
    input  i_Step,
    input  i_Mem_Cycle,
    input  i_Mem_Ack,
    output o_Step_Enable,
    output o_Step_Reset,
    output o_Mem_Req
  );

  modport slave (
    output i_Step,
    output i_Mem_Cycle,
    output i_Mem_Ack,
    input  o_Step_Enable,
    input  o_Step_Reset,
    input  o_Mem_Req
  );
endinterface

// File: rtl/cu_step_sequencer.sv
// Control-unit step sequencer. It splits the step count into M-cycle and
// T-state, and drives the step counter's enable and synchronous reset.
// The counter is frozen on memory wait states and cleared at the last step
// of each instruction. The sequencer also handles HALT and core run/stop,
// and keeps a saturating count of stalled cycles.
module cu_step_sequencer #(
  parameter int T_PER_M     = 4,
  parameter int MAX_MCYCLES = 6,
  parameter int WAIT_W      = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  cu_step_sequencer_if.master  bus,
  input  logic                 i_Run,
  input  logic [2:0]           i_MCycles,
  input  logic                 i_Halt,
  input  logic                 i_Int_Pending,
  output logic [2:0]           o_MCycle,
  output logic [1:0]           o_TState,
  output logic                 o_Instr_Done,
  output logic                 o_Halted,
  output logic [WAIT_W-1:0]    o_Wait_Cnt
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_MEM, HALT} state_t;

  state_t              state_q, state_d;
  logic                mem_done_q, mem_done_d;
  logic                done_q, done_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [2:0]          mc;
  logic [5:0]          last_step;
  logic                is_last;
  logic                stall;
  logic                step_enable;
  logic                step_reset;
  logic                mem_req;
  logic                halted;
  logic                wait_inc;
  logic                mem_done_set;

  // T_PER_M is a power of two, so these reduce to a shift and a mask.
  assign o_MCycle = 3'(bus.i_Step / T_PER_M);
  assign o_TState = 2'(bus.i_Step % T_PER_M);

  // Clamp the decoder's M-cycle count into the legal range 1..MAX_MCYCLES.
  always_comb begin
    if (i_MCycles == 3'd0)
      mc = 3'd1;
    else if (i_MCycles > 3'(MAX_MCYCLES))
      mc = 3'(MAX_MCYCLES);
    else
      mc = i_MCycles;
  end

  // Steps beyond the last legal one are treated as the last step, so a
  // corrupted counter still ends the instruction cleanly.
  assign last_step = 6'(mc * T_PER_M - 1);
  assign is_last   = ({1'b0, bus.i_Step} >= last_step);

  // A bus access that has not completed by T2 freezes the step counter.
  assign stall = (o_TState == 2'd2) && bus.i_Mem_Cycle && !mem_done_q && !bus.i_Mem_Ack;

  // Next-state and output decode for the run/wait/halt controller.
  always_comb begin
    state_d      = state_q;
    step_enable  = 1'b1;
    step_reset   = 1'b0;
    mem_req      = 1'b0;
    halted       = 1'b0;
    wait_inc     = 1'b0;
    mem_done_set = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        step_reset = 1'b1;
        if (i_Run) state_d = RUN;
      end
      RUN: begin
        mem_req = bus.i_Mem_Cycle && (o_TState == 2'd1 || o_TState == 2'd2) && !mem_done_q;
        if (stall) begin
          step_enable = 1'b0;
          wait_inc    = 1'b1;
          state_d     = WAIT_MEM;
        end else if (is_last) begin
          step_reset = 1'b1;
          done_d     = 1'b1;
          if (i_Halt)
            state_d = HALT;
          else if (!i_Run)
            state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        step_enable = 1'b0;
        mem_req     = 1'b1;
        wait_inc    = 1'b1;
        if (bus.i_Mem_Ack) begin
          mem_done_set = 1'b1;
          state_d      = RUN;
        end
      end
      HALT: begin
        step_enable = 1'b0;
        halted      = 1'b1;
        if (i_Int_Pending)
          state_d = RUN;
        else if (!i_Run)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mem_done only lives for the rest of the T2 step it was set in; the
  // wait counter saturates instead of wrapping.
  always_comb begin
    mem_done_d = (o_TState == 2'd2) && (mem_done_q || mem_done_set);
    wait_cnt_d = wait_cnt_q;
    if (wait_inc && (wait_cnt_q != {WAIT_W{1'b1}}))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // State and status registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      mem_done_q <= 1'b0;
      done_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_done_q <= mem_done_d;
      done_q     <= done_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.o_Step_Enable = step_enable;
  assign bus.o_Step_Reset  = step_reset;
  assign bus.o_Mem_Req     = mem_req;
  assign o_Halted          = halted;
  assign o_Instr_Done      = done_q;
  assign o_Wait_Cnt        = wait_cnt_q;

endmodule

// File: tb/tb_cu_step_sequencer.sv
// Testbench for cu_step_sequencer: models the step counter the sequencer
// controls, runs hand-written multi-cycle sequences, then a table of
// combinational decode vectors with the step value overridden.
module tb_cu_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [2:0] mcycles;
  logic       halt;
  logic       int_pending;
  logic [2:0] o_mcycle;
  logic [1:0] o_tstate;
  logic       o_done;
  logic       o_halted;
  logic [7:0] o_wait_cnt;

  logic [4:0] step_cnt = 5'd0;
  logic       step_override_en = 1'b0;
  logic [4:0] step_override = 5'd0;

  int n_compared = 0;
  int n_failed   = 0;

  cu_step_sequencer_if bus ();

  cu_step_sequencer #(
    .T_PER_M    (4),
    .MAX_MCYCLES(6),
    .WAIT_W     (8)
  ) dut (
    .i_Clk        (clk),
    .i_Reset_n    (rst_n),
    .bus          (bus.master),
    .i_Run        (run),
    .i_MCycles    (mcycles),
    .i_Halt       (halt),
    .i_Int_Pending(int_pending),
    .o_MCycle     (o_mcycle),
    .o_TState     (o_tstate),
    .o_Instr_Done (o_done),
    .o_Halted     (o_halted),
    .o_Wait_Cnt   (o_wait_cnt)
  );

  always #5 clk = ~clk;

  // Step counter model: synchronous reset has priority over enable.
  always @(posedge clk) begin
    if (bus.o_Step_Reset)
      step_cnt <= 5'd0;
    else if (bus.o_Step_Enable)
      step_cnt <= step_cnt + 5'd1;
  end

  assign bus.i_Step = step_override_en ? step_override : step_cnt;

  typedef struct {
    logic [4:0] step;
    logic [2:0] mc;
    logic       mem;
    logic       ack;
    logic [2:0] exp_mcycle;
    logic [1:0] exp_tstate;
    logic       exp_en;
    logic       exp_rst;
    logic       exp_req;
  } vec_t;

  vec_t vecs [15];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_step(input logic [4:0] target, input int max_cycles, input string name);
    int n = 0;
    while (bus.i_Step !== target && n < max_cycles) begin
      next_cycle();
      n++;
    end
    check_output(name, 32'(bus.i_Step), 32'(target));
  endtask

  task automatic run_to_last(input logic [4:0] exp_last, input string name);
    int n = 0;
    logic [4:0] seen = 5'd31;
    while (n < 40) begin
      next_cycle();
      n++;
      if (bus.o_Step_Reset && bus.i_Step != 5'd0) begin
        seen = bus.i_Step;
        break;
      end
    end
    check_output(name, 32'(seen), 32'(exp_last));
  endtask

  task automatic apply_stimulus(input vec_t v);
    step_override   = v.step;
    mcycles         = v.mc;
    bus.i_Mem_Cycle = v.mem;
    bus.i_Mem_Ack   = v.ack;
    #1;
  endtask

  initial begin
    int frozen;

    vecs[0]  = '{5'd0,  3'd1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{5'd3,  3'd1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{5'd2,  3'd0, 1'b0, 1'b0, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{5'd3,  3'd0, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{5'd5,  3'd2, 1'b1, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{5'd6,  3'd2, 1'b1, 1'b1, 3'd1, 2'd2, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'd7,  3'd2, 1'b1, 1'b0, 3'd1, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{5'd23, 3'd7, 1'b0, 1'b0, 3'd5, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{5'd22, 3'd7, 1'b0, 1'b0, 3'd5, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{5'd19, 3'd6, 1'b0, 1'b0, 3'd4, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{5'd23, 3'd6, 1'b0, 1'b0, 3'd5, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{5'd12, 3'd3, 1'b0, 1'b0, 3'd3, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{5'd31, 3'd6, 1'b0, 1'b0, 3'd7, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{5'd4,  3'd1, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{5'd2,  3'd1, 1'b1, 1'b1, 3'd0, 2'd2, 1'b1, 1'b0, 1'b1};

    rst_n           = 1'b0;
    run             = 1'b1;
    mcycles         = 3'd1;
    halt            = 1'b0;
    int_pending     = 1'b0;
    bus.i_Mem_Cycle = 1'b0;
    bus.i_Mem_Ack   = 1'b0;

    // Reset values
    next_cycle();
    next_cycle();
    check_output("rst_enable",  32'(bus.o_Step_Enable), 32'd1);
    check_output("rst_reset",   32'(bus.o_Step_Reset),  32'd1);
    check_output("rst_memreq",  32'(bus.o_Mem_Req),     32'd0);
    check_output("rst_halted",  32'(o_halted),          32'd0);
    check_output("rst_done",    32'(o_done),            32'd0);
    check_output("rst_waitcnt", 32'(o_wait_cnt),        32'd0);
    check_output("rst_step",    32'(bus.i_Step),        32'd0);

    // Single M-cycle instruction, no memory access
    rst_n = 1'b1;
    next_cycle();
    check_output("t1_step0",  32'(bus.i_Step),       32'd0);
    check_output("t1_reset0", 32'(bus.o_Step_Reset), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      check_output("t1_step", 32'(bus.i_Step), 32'(k));
    end
    check_output("t1_last_reset", 32'(bus.o_Step_Reset), 32'd1);
    check_output("t1_done_early", 32'(o_done),           32'd0);
    next_cycle();
    check_output("t1_wrap_step", 32'(bus.i_Step), 32'd0);
    check_output("t1_done",      32'(o_done),     32'd1);
    next_cycle();
    check_output("t1_step1",     32'(bus.i_Step), 32'd1);
    check_output("t1_done_once", 32'(o_done),     32'd0);

    // Two M-cycles with a memory wait at T2 of M-cycle 1
    mcycles = 3'd2;
    wait_step(5'd5, 20, "t2_reach5");
    bus.i_Mem_Cycle = 1'b1;
    bus.i_Mem_Ack   = 1'b0;
    #1;
    check_output("t2_req_t1", 32'(bus.o_Mem_Req), 32'd1);
    next_cycle();
    frozen = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.i_Mem_Ack = 1'b1;
      #1;
      if (bus.i_Step == 5'd6 && !bus.o_Step_Enable && bus.o_Mem_Req) frozen++;
      next_cycle();
    end
    bus.i_Mem_Ack = 1'b0;
    #1;
    check_output("t2_frozen",    32'(frozen),            32'd4);
    check_output("t2_step_held", 32'(bus.i_Step),        32'd6);
    check_output("t2_enable",    32'(bus.o_Step_Enable), 32'd1);
    check_output("t2_req_off",   32'(bus.o_Mem_Req),     32'd0);
    check_output("t2_waitcnt",   32'(o_wait_cnt),        32'd4);
    next_cycle();
    check_output("t2_step7",  32'(bus.i_Step),       32'd7);
    check_output("t2_last",   32'(bus.o_Step_Reset), 32'd1);
    bus.i_Mem_Cycle = 1'b0;
    next_cycle();
    check_output("t2_done", 32'(o_done), 32'd1);

    // HALT at the end of a single M-cycle instruction, woken by interrupt
    mcycles = 3'd1;
    halt    = 1'b1;
    wait_step(5'd3, 10, "t3_reach3");
    next_cycle();
    check_output("t3_halted",  32'(o_halted),          32'd1);
    check_output("t3_step0",   32'(bus.i_Step),        32'd0);
    check_output("t3_enable",  32'(bus.o_Step_Enable), 32'd0);
    check_output("t3_done",    32'(o_done),            32'd1);
    next_cycle();
    check_output("t3_hold",    32'(bus.i_Step),        32'd0);
    int_pending = 1'b1;
    next_cycle();
    check_output("t3_wake",      32'(o_halted),   32'd0);
    check_output("t3_wake_step", 32'(bus.i_Step), 32'd0);
    int_pending = 1'b0;
    halt        = 1'b0;
    next_cycle();
    check_output("t3_step1", 32'(bus.i_Step), 32'd1);

    // Run dropped mid-instruction: finish to step 11, then IDLE
    mcycles = 3'd3;
    run     = 1'b0;
    wait_step(5'd11, 20, "t4_reach11");
    check_output("t4_last", 32'(bus.o_Step_Reset), 32'd1);
    next_cycle();
    check_output("t4_done",  32'(o_done),     32'd1);
    check_output("t4_step0", 32'(bus.i_Step), 32'd0);
    next_cycle();
    check_output("t4_idle_step",  32'(bus.i_Step),       32'd0);
    check_output("t4_idle_reset", 32'(bus.o_Step_Reset), 32'd1);
    check_output("t4_done_once",  32'(o_done),           32'd0);

    // Reset asserted while waiting on memory at step 10
    run = 1'b1;
    next_cycle();
    wait_step(5'd9, 20, "t5_reach9");
    bus.i_Mem_Cycle = 1'b1;
    bus.i_Mem_Ack   = 1'b0;
    next_cycle();
    next_cycle();
    check_output("t5_wait_step", 32'(bus.i_Step),    32'd10);
    check_output("t5_wait_req",  32'(bus.o_Mem_Req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("t5_req_drop",  32'(bus.o_Mem_Req),      32'd0);
    check_output("t5_rst_reset", 32'(bus.o_Step_Reset),   32'd1);
    check_output("t5_rst_wait",  32'(o_wait_cnt),         32'd0);
    run             = 1'b0;
    bus.i_Mem_Cycle = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    check_output("t5_step0",  32'(bus.i_Step),       32'd0);
    check_output("t5_idle",   32'(bus.o_Step_Reset), 32'd1);
    check_output("t5_waitcnt", 32'(o_wait_cnt),      32'd0);

    // M-cycle count clamping
    mcycles = 3'd0;
    run     = 1'b1;
    run_to_last(5'd3, "t6_mc0_last");
    next_cycle();
    mcycles = 3'd7;
    run_to_last(5'd23, "t6_mc7_last");
    next_cycle();

    // Wait counter saturation
    mcycles         = 3'd1;
    bus.i_Mem_Cycle = 1'b1;
    bus.i_Mem_Ack   = 1'b0;
    for (int i = 0; i < 300; i++) next_cycle();
    check_output("t6_sat",      32'(o_wait_cnt), 32'd255);
    check_output("t6_sat_step", 32'(bus.i_Step), 32'd2);
    for (int i = 0; i < 10; i++) next_cycle();
    check_output("t6_sat_hold", 32'(o_wait_cnt), 32'd255);
    bus.i_Mem_Ack = 1'b1;
    next_cycle();
    bus.i_Mem_Ack   = 1'b0;
    bus.i_Mem_Cycle = 1'b0;

    // Table-driven decode checks in RUN with the step value overridden
    step_override_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_mcycle", i), 32'(o_mcycle),          32'(vecs[i].exp_mcycle));
      check_output($sformatf("vec%0d_tstate", i), 32'(o_tstate),          32'(vecs[i].exp_tstate));
      check_output($sformatf("vec%0d_enable", i), 32'(bus.o_Step_Enable), 32'(vecs[i].exp_en));
      check_output($sformatf("vec%0d_reset",  i), 32'(bus.o_Step_Reset),  32'(vecs[i].exp_rst));
      check_output($sformatf("vec%0d_memreq", i), 32'(bus.o_Mem_Req),     32'(vecs[i].exp_req));
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
